// File: rtl/sar_compare_search_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_compare_search_if
// Description : Probe/flag bundle between the SAR search controller and the
//               magnitude comparator, plus the controller's status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_compare_search_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(WIDTH) + 1;

    logic             start;
    logic             C2;
    logic             C1;
    logic             C0;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic [PW-1:0]    probes;

    modport master (
        input  start, C2, C1, C0,
        output B, busy, done, err, result, probes
    );

    modport slave (
        output start, C2, C1, C0,
        input  B, busy, done, err, result, probes
    );
endinterface
`default_nettype wire

// File: rtl/sar_compare_search.sv
`default_nettype none
// ============================================================================
// Module      : sar_compare_search
// Description : Successive-approximation search over comparator operand B,
//               MSB to LSB with early exit on equality.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_compare_search #(
    parameter int WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    sar_compare_search_if.master    bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = $clog2(WIDTH) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TEST = 1'b1;

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic [PW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [PW-1:0]    probes_q, probes_d;

    logic [2:0]       w_flags;
    logic             w_onehot;
    logic             w_finish;
    logic             w_fail;
    logic [WIDTH-1:0] w_b_step;
    logic [IW-1:0]    w_idx_dn;

    assign w_flags  = {bus.C2, bus.C1, bus.C0};
    assign w_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
    assign w_idx_dn = idx_q - IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            probes_q <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            probes_q <= probes_d;
        end
    end

    // A>B at the LSB cannot happen with a correct comparator, so it is an error.
    always_comb begin
        state_d  = state_q;
        w_finish = 1'b0;
        w_fail   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_TEST;
            end
            S_TEST: begin
                if (!w_onehot) begin
                    w_finish = 1'b1;
                    w_fail   = 1'b1;
                end else if (bus.C2) begin
                    w_finish = 1'b1;
                end else if (idx_q == '0) begin
                    w_finish = 1'b1;
                    w_fail   = bus.C1;
                end
                if (w_finish) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        probes_d = probes_q;
        // The trial bit survives only when A>B.
        w_b_step         = b_q;
        w_b_step[idx_q]  = bus.C1;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    b_d    = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d  = IW'(WIDTH - 1);
                    cnt_d  = PW'(1);
                    busy_d = 1'b1;
                end
            end
            S_TEST: begin
                if (w_finish) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    probes_d = cnt_q;
                    b_d      = '0;
                    err_d    = w_fail;
                    if (w_fail)      result_d = '0;
                    else if (bus.C2) result_d = b_q;
                    else             result_d = w_b_step;
                end else begin
                    b_d           = w_b_step;
                    b_d[w_idx_dn] = 1'b1;
                    idx_d         = w_idx_dn;
                    cnt_d         = cnt_q + PW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.B      = b_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign bus.probes = probes_q;
endmodule
`default_nettype wire

// File: tb/tb_sar_compare_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_compare_search
// Description : Scoreboard bench with a behavioral comparator driving flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_compare_search;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic [3:0] result;
        logic [2:0] probes;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [3:0] r_a;
    logic fault;
    int   nchecks;
    int   nerr;
    logic [3:0] probe_q[$];
    exp_t       res_q[$];

    sar_compare_search_if #(.WIDTH(WIDTH)) bus ();

    sar_compare_search #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (fault) begin
            bus.C2 = 1'b1; bus.C1 = 1'b1; bus.C0 = 1'b0;
        end else begin
            bus.C2 = (r_a == bus.B);
            bus.C1 = (r_a >  bus.B);
            bus.C0 = (r_a <  bus.B);
        end
    end

    task automatic push_probes(input logic [3:0] p[$]);
        foreach (p[i]) probe_q.push_back(p[i]);
    endtask

    // Arithmetic binary-search model: step halves each probe.
    task automatic push_model(input int a);
        int b, step, n;
        b = 8; step = 8; n = 0;
        forever begin
            n++;
            probe_q.push_back(4'(b));
            if (a == b) begin
                res_q.push_back('{result: 4'(b), probes: 3'(n), err: 1'b0});
                break;
            end
            if (step == 1) begin
                if (a < b) res_q.push_back('{result: 4'(b - 1), probes: 3'(n), err: 1'b0});
                else       res_q.push_back('{result: 4'd0, probes: 3'(n), err: 1'b1});
                break;
            end
            if (a > b) b = b + step / 2;
            else       b = b - step / 2;
            step = step / 2;
        end
    endtask

    task automatic launch(input logic [3:0] a);
        r_a = a;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called on the negedge right after the start edge; returns on the done negedge.
    task automatic wait_done(input int pulse_at);
        int   cyc;
        exp_t e;
        cyc = 1;
        forever begin
            if (cyc == pulse_at) bus.start = 1'b1;
            else                 bus.start = 1'b0;
            if (bus.done) break;
            nchecks++;
            if (bus.busy !== 1'b1) begin
                nerr++; $display("FAIL busy_during_search cyc=%0d got=%b want=1", cyc, bus.busy);
            end
            nchecks++;
            if (probe_q.size() == 0) begin
                nerr++; $display("FAIL probe_extra cyc=%0d got B=%0d want no further probe", cyc, bus.B);
            end else begin
                logic [3:0] p;
                p = probe_q.pop_front();
                if (bus.B !== p) begin
                    nerr++; $display("FAIL probe cyc=%0d got B=%0d want %0d", cyc, bus.B, p);
                end
            end
            if (cyc > 20) begin
                nchecks++; nerr++;
                $display("FAIL done_timeout got no done after %0d cycles want done", cyc);
                bus.start = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        if (res_q.size() == 0) begin
            nchecks++; nerr++;
            $display("FAIL unexpected_done got done want none");
            return;
        end
        e = res_q.pop_front();
        nchecks++;
        if (bus.result !== e.result || bus.probes !== e.probes || bus.err !== e.err) begin
            nerr++;
            $display("FAIL result got r=%0d p=%0d e=%b want r=%0d p=%0d e=%b",
                     bus.result, bus.probes, bus.err, e.result, e.probes, e.err);
        end
        nchecks++;
        if (cyc !== int'(e.probes) + 1) begin
            nerr++; $display("FAIL latency got cycle %0d want %0d", cyc, int'(e.probes) + 1);
        end
        nchecks++;
        if (bus.busy !== 1'b0 || bus.B !== 4'd0 || probe_q.size() != 0) begin
            nerr++; $display("FAIL end_state got busy=%b B=%0d left=%0d want 0 0 0",
                             bus.busy, bus.B, probe_q.size());
        end
    endtask

    task automatic check_zero(input string name);
        nchecks++;
        if (bus.B !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.result !== 4'd0 || bus.probes !== 3'd0) begin
            nerr++;
            $display("FAIL %s got B=%0d busy=%b done=%b err=%b result=%0d probes=%0d want all 0",
                     name, bus.B, bus.busy, bus.done, bus.err, bus.result, bus.probes);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset_values");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_reset_idle");
    endtask

    task automatic test_directed();
        push_probes('{4'd8});
        res_q.push_back('{result: 4'd8, probes: 3'd1, err: 1'b0});
        launch(4'd8); wait_done(0);
        push_probes('{4'd8, 4'd4, 4'd2, 4'd1});
        res_q.push_back('{result: 4'd0, probes: 3'd4, err: 1'b0});
        launch(4'd0); wait_done(0);
        push_probes('{4'd8, 4'd12, 4'd14, 4'd15});
        res_q.push_back('{result: 4'd15, probes: 3'd4, err: 1'b0});
        launch(4'd15); wait_done(0);
        push_probes('{4'd8, 4'd4, 4'd6, 4'd5});
        res_q.push_back('{result: 4'd5, probes: 3'd4, err: 1'b0});
        launch(4'd5); wait_done(0);
        @(negedge clk);
        nchecks++;
        if (bus.done !== 1'b0 || bus.result !== 4'd5) begin
            nerr++; $display("FAIL done_one_cycle got done=%b result=%0d want 0 5", bus.done, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) begin
            push_model(a);
            launch(4'(a));
            wait_done(0);
        end
        @(negedge clk);
    endtask

    task automatic test_fault();
        fault = 1'b1;
        push_probes('{4'd8});
        res_q.push_back('{result: 4'd0, probes: 3'd1, err: 1'b1});
        launch(4'd6); wait_done(0);
        fault = 1'b0;
        @(negedge clk);
        push_model(6);
        launch(4'd6); wait_done(0);
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        push_probes('{4'd8, 4'd4, 4'd6, 4'd5});
        res_q.push_back('{result: 4'd5, probes: 3'd4, err: 1'b0});
        launch(4'd5); wait_done(2);
        @(negedge clk);
        nchecks++;
        if (bus.busy !== 1'b0) begin
            nerr++; $display("FAIL start_while_busy_queued got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_search();
        bit saw_done;
        launch(4'd0);
        @(negedge clk);
        nchecks++;
        if (bus.B !== 4'd4) begin
            nerr++; $display("FAIL mid_probe2 got B=%0d want 4", bus.B);
        end
        #1 rst_n = 1'b0;
        #1;
        check_zero("abort_reset");
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        nchecks++;
        if (saw_done) begin
            nerr++; $display("FAIL abort_no_done got done pulse want none");
        end
        check_zero("abort_idle");
        push_model(9);
        launch(4'd9); wait_done(0);
    endtask

    initial begin
        nchecks = 0; nerr = 0;
        bus.start = 1'b0;
        fault = 1'b0;
        r_a = 4'd0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_fault();
        test_start_while_busy();
        test_reset_mid_search();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
`default_nettype wire
